// File: rtl/sat_accum_pkg.sv
// rtl/sat_accum_pkg.sv - shared types and constants for the saturating accumulator
package sat_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] SAT_POS = 16'h7FFF;
    localparam logic [15:0] SAT_NEG = 16'h8000;

    typedef logic signed [16:0] wide_t;

endpackage

// File: rtl/sat_accum_if.sv
// rtl/sat_accum_if.sv - control, operand stream and result bundle for sat_accum_16
interface sat_accum_if #(
    parameter int COUNT_W = 8
);
    logic               start;
    logic [COUNT_W-1:0] len;
    logic               sub;
    logic               in_valid;
    logic [15:0]        in_data;
    logic               in_ready;
    logic [15:0]        acc;
    logic               ovfl;
    logic               busy;
    logic               done;

    modport master (
        output start, len, sub, in_valid, in_data,
        input  in_ready, acc, ovfl, busy, done
    );

    modport slave (
        input  start, len, sub, in_valid, in_data,
        output in_ready, acc, ovfl, busy, done
    );
endinterface

// File: rtl/sat_addsub_step.sv
// rtl/sat_addsub_step.sv - one signed add/sub step; SAT_ACCUM_SAT_EN selects clamping over wrap
module sat_addsub_step
    import sat_accum_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] result,
    output logic        oor
);

    wide_t r;

    // 17-bit sum/difference of the sign-extended operands; out of range when bits 16 and 15 differ
    always_comb begin
        if (sub) begin
            r = wide_t'({a[15], a}) - wide_t'({b[15], b});
        end else begin
            r = wide_t'({a[15], a}) + wide_t'({b[15], b});
        end
        oor = r[16] ^ r[15];
`ifdef SAT_ACCUM_SAT_EN
        if (oor) begin
            result = r[16] ? SAT_NEG : SAT_POS;
        end else begin
            result = r[15:0];
        end
`else
        result = r[15:0];
`endif
    end

endmodule

// File: rtl/sat_accum_16.sv
// rtl/sat_accum_16.sv - streaming saturating accumulator; SAT_ACCUM_SAT_EN enables clamping
module sat_accum_16
    import sat_accum_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    sat_accum_if.slave   bus
);

    state_t             state_q, state_d;
    logic [15:0]        acc_q, acc_d;
    logic               ovfl_q, ovfl_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               sub_q, sub_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [15:0]        step_res;
    logic               step_oor;

    sat_addsub_step u_step (
        .a      (acc_q),
        .b      (bus.in_data),
        .sub    (sub_q),
        .result (step_res),
        .oor    (step_oor)
    );

    // Next-state logic: run setup on start, one accumulate step per accepted sample
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovfl_d  = ovfl_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    acc_d  = 16'h0000;
                    ovfl_d = 1'b0;
                    cnt_d  = bus.len;
                    sub_d  = bus.sub;
                    if (bus.len != '0) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.in_valid) begin
                    acc_d  = step_res;
                    ovfl_d = ovfl_q | step_oor;
                    cnt_d  = cnt_q - 1'b1;
                    if (cnt_q == COUNT_W'(1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
    end

    // State and result registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 16'h0000;
            ovfl_q  <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovfl_q  <= ovfl_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs: ready depends only on the current state, never on in_valid
    always_comb begin
        bus.in_ready = (state_q == ST_RUN);
        bus.acc      = acc_q;
        bus.ovfl     = ovfl_q;
        bus.busy     = busy_q;
        bus.done     = done_q;
    end

endmodule

// File: tb/tb_sat_accum_16.sv
// tb/tb_sat_accum_16.sv - self-checking bench for sat_accum_16 against a behavioural model
module tb_sat_accum_16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [15:0] exp_acc;
    bit          exp_ovf;
    logic [15:0] samp_q[$];
    bit          vpat_q[$];

    sat_accum_if #(.COUNT_W(8)) bus ();

    sat_accum_16 #(.COUNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference step from the arithmetic rules: plain integer math, then clamp or wrap
    function automatic logic [15:0] ref_step(input logic [15:0] a, input logic [15:0] b,
                                             input bit s, inout bit ov);
        int ai;
        int bi;
        int r;
        logic [15:0] w;
        ai = $signed(a);
        bi = $signed(b);
        r  = s ? (ai - bi) : (ai + bi);
        if (r > 32767 || r < -32768) ov = 1'b1;
`ifdef SAT_ACCUM_SAT_EN
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
`endif
        w = r[15:0];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run: samples from samp_q (random if short), valid from vpat_q or gap_pct
    task automatic do_run(input int n, input bit s, input int gap_pct,
                          input bit mid_start, input bit idle_after);
        int idx;
        int cyc;
        bit v;
        logic [15:0] d;
        bus.start = 1'b1;
        bus.len   = n[7:0];
        bus.sub   = s;
        tick();
        bus.start = 1'b0;
        exp_acc = 16'h0000;
        exp_ovf = 1'b0;
        chk("setup_acc", {16'h0, bus.acc}, 32'h0);
        chk("setup_ovfl", {31'h0, bus.ovfl}, 32'h0);
        if (n == 0) begin
            chk("len0_done", {31'h0, bus.done}, 32'h1);
            chk("len0_ready", {31'h0, bus.in_ready}, 32'h0);
            chk("len0_busy", {31'h0, bus.busy}, 32'h0);
        end else begin
            chk("setup_done", {31'h0, bus.done}, 32'h0);
        end
        idx = 0;
        cyc = 0;
        while (idx < n && cyc < 400) begin
            chk("run_ready", {31'h0, bus.in_ready}, 32'h1);
            chk("run_busy", {31'h0, bus.busy}, 32'h1);
            if (vpat_q.size() > 0) v = vpat_q.pop_front();
            else v = ($urandom_range(99) >= gap_pct);
            d = (samp_q.size() > 0) ? samp_q[0] : 16'($urandom);
            bus.in_valid = v;
            bus.in_data  = v ? d : 16'($urandom);
            if (mid_start && cyc == 2) begin
                bus.start = 1'b1;
                bus.len   = 8'(n + 3);
                bus.sub   = ~s;
            end
            tick();
            bus.start    = 1'b0;
            bus.in_valid = 1'b0;
            if (v) begin
                if (samp_q.size() > 0) void'(samp_q.pop_front());
                exp_acc = ref_step(exp_acc, d, s, exp_ovf);
                idx++;
            end
            cyc++;
            if (idx < n) chk("early_done", {31'h0, bus.done}, 32'h0);
        end
        if (idx < n) chk("run_timeout", 32'(idx), 32'(n));
        chk("final_acc", {16'h0, bus.acc}, {16'h0, exp_acc});
        chk("final_ovfl", {31'h0, bus.ovfl}, {31'h0, exp_ovf});
        chk("final_done", {31'h0, bus.done}, 32'h1);
        chk("final_busy", {31'h0, bus.busy}, 32'h0);
        chk("final_ready", {31'h0, bus.in_ready}, 32'h0);
        vpat_q.delete();
        samp_q.delete();
        if (idle_after) begin
            tick();
            chk("done_pulse_end", {31'h0, bus.done}, 32'h0);
            chk("hold_acc", {16'h0, bus.acc}, {16'h0, exp_acc});
            chk("hold_ovfl", {31'h0, bus.ovfl}, {31'h0, exp_ovf});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.sub      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #2;
        chk("rst_acc", {16'h0, bus.acc}, 32'h0);
        chk("rst_ovfl", {31'h0, bus.ovfl}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        chk("rst_ready", {31'h0, bus.in_ready}, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_ready", {31'h0, bus.in_ready}, 32'h0);

        // Basic accumulate, back-to-back; next run starts in the done cycle
        samp_q = '{16'h1000, 16'h2000, 16'h0003};
        do_run(3, 1'b0, 0, 1'b0, 1'b0);
        chk("basic_const", {16'h0, bus.acc}, 32'h3003);

        // Positive overflow, then recovery from the clamped value
        samp_q = '{16'h7000, 16'h2000};
        do_run(2, 1'b0, 0, 1'b0, 1'b1);
`ifdef SAT_ACCUM_SAT_EN
        chk("possat_const", {16'h0, bus.acc}, 32'h7FFF);
`else
        chk("possat_const", {16'h0, bus.acc}, 32'h9000);
`endif
        samp_q = '{16'h7000, 16'h2000, 16'hF000};
        do_run(3, 1'b0, 0, 1'b0, 1'b1);
`ifdef SAT_ACCUM_SAT_EN
        chk("recover_const", {16'h0, bus.acc}, 32'h6FFF);
`else
        chk("recover_const", {16'h0, bus.acc}, 32'h8000);
`endif
        chk("recover_ovfl", {31'h0, bus.ovfl}, 32'h1);

        // Subtract edges
        samp_q = '{16'h8000};
        do_run(1, 1'b1, 0, 1'b0, 1'b1);
`ifdef SAT_ACCUM_SAT_EN
        chk("sub_min_const", {16'h0, bus.acc}, 32'h7FFF);
`else
        chk("sub_min_const", {16'h0, bus.acc}, 32'h8000);
`endif
        samp_q = '{16'h7FFF, 16'h0002};
        do_run(2, 1'b1, 0, 1'b0, 1'b1);
`ifdef SAT_ACCUM_SAT_EN
        chk("sub_neg_const", {16'h0, bus.acc}, 32'h8000);
`else
        chk("sub_neg_const", {16'h0, bus.acc}, 32'h7FFF);
`endif

        // Backpressure with a start pulse mid-run
        vpat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        samp_q = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        do_run(4, 1'b0, 0, 1'b1, 1'b1);
        chk("bp_const", {16'h0, bus.acc}, 32'h0A0A);

        // Zero-length run
        do_run(0, 1'b0, 0, 1'b0, 1'b1);

        // Reset mid-run after two of five samples
        bus.start = 1'b1;
        bus.len   = 8'd5;
        bus.sub   = 1'b0;
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h7000;
        tick();
        tick();
        bus.in_valid = 1'b0;
        chk("pre_rst_ovfl", {31'h0, bus.ovfl}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", {16'h0, bus.acc}, 32'h0);
        chk("mid_rst_ovfl", {31'h0, bus.ovfl}, 32'h0);
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("mid_rst_ready", {31'h0, bus.in_ready}, 32'h0);
        tick();
        chk("mid_rst_done", {31'h0, bus.done}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_done", {31'h0, bus.done}, 32'h0);
        chk("post_rst_ready", {31'h0, bus.in_ready}, 32'h0);
        samp_q = '{16'h0010, 16'h0020};
        do_run(2, 1'b0, 0, 1'b0, 1'b1);

        // Randomized runs: large magnitudes to exercise both clamps, random gaps
        for (int k = 0; k < 40; k++) begin
            int n;
            n = $urandom_range(12, 0);
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(1) == 1) samp_q.push_back(16'($urandom_range(16'hFFFF, 16'h6000)) ^ 16'h8000);
                else samp_q.push_back(16'($urandom));
            end
            do_run(n, 1'($urandom_range(1)), $urandom_range(50), 1'($urandom_range(1)),
                   1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sat_accum_16.md
# sat_accum_16

Sequential saturating accumulator for the ALU datapath. It consumes a stream of signed 16-bit operands over a valid/ready handshake and adds or subtracts each one into a running accumulator. The add/subtract clamps to 16'h7FFF / 16'h8000 on overflow. After a programmed number of samples it reports the result, a sticky overflow flag and a one-cycle `done` pulse. It sits directly downstream of the operand/register-read path and upstream of writeback, and it reuses the same saturating add/sub arithmetic as the single-cycle ALU.

## Interface
- `COUNT_W`, default 8: width of the sample-count field; a run has at most 2^COUNT_W−1 samples.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `start`  in  1  begin a new run; sampled only in IDLE or DONE.
- `len`  in  COUNT_W  number of samples in the run; latched on an accepted `start`.
- `sub`  in  1  0 = add samples, 1 = subtract samples; latched on an accepted `start`.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  16  signed two's-complement sample.
- `in_ready`  out  1  block accepts a sample this cycle.
- `acc`  out  16  signed accumulator value.
- `ovfl`  out  1  sticky; set if any step of the run saturated (or wrapped).
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when the run completes.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset: state = IDLE; `acc` = 0; `ovfl` = 0; `busy` = 0; `done` = 0; `in_ready` = 0; internal count = 0.
- IDLE/DONE with `start` = 1:
  - `acc` and `ovfl` clear to 0; count loads `len`; `sub` is latched.
  - Next state is RUN if `len` ≠ 0, else DONE.
- `start` in RUN is ignored. `len` and `sub` changes in RUN are ignored.
- RUN:
  - `in_ready` = 1.
  - A transfer happens when `in_valid && in_ready`. On each transfer, `acc` ← sat(`acc` ± `in_data`) and count decrements.
  - When the transfer that makes count reach 0 occurs, next state is DONE.
- DONE: holds `acc` and `ovfl` until the next accepted `start`. `in_ready` = 0.
- Arithmetic:
  - Compute r = acc ± in_data in 17-bit signed, sign-extending both operands.
  - If r > 32767, the result is 16'h7FFF. If r < −32768, the result is 16'h8000. Otherwise the result is r[15:0].
  - `ovfl` |= (r outside range).
  - Subtracting 16'h8000 from a non-negative `acc` saturates to 16'h7FFF. Example: 0 − (−32768) = 16'h7FFF with `ovfl` = 1.
- Saturation is per step. Later samples continue from the clamped value; there is no hidden wide accumulator.
- `in_valid` gaps stall the run indefinitely without changing state.

## Timing
- One sample per cycle maximum. `acc` is registered and updates on the same edge as the transfer.
- The final transfer at edge k moves the state to DONE at edge k. `done` = 1 for exactly the cycle after edge k, and `acc`/`ovfl` are final in that cycle.
- `len` = 0: `start` at edge k gives DONE at edge k, `done` high in the following cycle, `acc` = 0, `ovfl` = 0.
- `start` in the `done` cycle is accepted. `done` still pulses only that one cycle, and RUN begins at the next edge.
- `rst_n` low mid-run: all outputs go to reset values immediately (asynchronous). The run is abandoned, with no `done` pulse.
- `busy` equals (state == RUN), registered. `in_ready` is combinational from the state only, with no path from `in_valid`.

## Configuration
- `SAT_ACCUM_SAT_EN` defined: clamping exactly as in Operation.
- `SAT_ACCUM_SAT_EN` undefined: the result is r[15:0] (two's-complement wrap). `ovfl` is still set sticky on any out-of-range step. Everything else is identical.

## Structure
- Package `sat_accum_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - constants SAT_POS = 16'h7FFF and SAT_NEG = 16'h8000;
  - a 17-bit signed intermediate typedef.
- One combinational sub-module, `sat_addsub_step`:
  - inputs: a, b, sub;
  - outputs: 16-bit result and a 1-bit out-of-range flag;
  - clamping is gated by `SAT_ACCUM_SAT_EN`.
- The top level holds the FSM, count register and accumulator register.

## Test plan
- Basic accumulate: `len` = 3, `sub` = 0, samples 16'h1000, 16'h2000, 16'h0003 back-to-back → `acc` = 16'h3003, `ovfl` = 0, `done` pulses the cycle after the 3rd transfer.
- Positive saturation then recovery: `len` = 2, samples 16'h7000, 16'h2000 → 16'h7FFF, `ovfl` = 1. A new run with `len` = 3 and samples 16'h7000, 16'h2000, 16'hF000 → 16'h6FFF, `ovfl` = 1. Without the macro, the 2-sample run gives 16'h9000.
- Subtract edge: `sub` = 1, `len` = 1, sample 16'h8000 from 0 → 16'h7FFF, `ovfl` = 1. `sub` = 1, `len` = 2, samples 16'h7FFF, 16'h0002 → 16'h8000, `ovfl` = 1.
- Backpressure and ignored start: `len` = 4 with `in_valid` toggling 1,0,0,1,1,0,1 and `start` pulsed mid-run → exactly 4 transfers, correct sum, `len` latched from the first `start`.
- `len` = 0: `start` → `done` the next cycle, `acc` = 0, `in_ready` never high.
- Reset mid-run after 2 of 5 samples → `acc` = 0, `ovfl` = 0, state IDLE, no `done`. A following run completes normally.
